// File: rtl/sr_pulse_gen.sv
// Conditions two bouncy async requests into clean, mutually exclusive one-shot
// set/reset pulses for a downstream SR latch (sync -> debounce -> edge -> arbiter).
module sr_pulse_gen #(
  parameter int DB_CYCLES = 16,
  parameter int PULSE_LEN = 1,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_raw,
  input  logic reset_raw,
  output logic set,
  output logic reset,
  output logic set_level,
  output logic reset_level,
  output logic conflict
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] P_LAST  = CNT_W'(PULSE_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SET_P = 2'd1,
    RST_P = 2'd2
  } state_t;

  // Channel 0 is set, channel 1 is reset.
  logic [1:0] w_raw;
  logic [1:0] w_level;
  logic [1:0] w_rise;

  assign w_raw = {reset_raw, set_raw};

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic             r_s1;
    logic             r_s2;
    logic             r_level;
    logic             r_level_q;
    logic [CNT_W-1:0] r_cnt;

    // NOTE: state updates use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s1      <= 1'b0;
        r_s2      <= 1'b0;
        r_level   <= 1'b0;
        r_level_q <= 1'b0;
        r_cnt     <= '0;
      end else begin
        r_s1      <= w_raw[g];
        r_s2      <= r_s1;
        r_level_q <= r_level;
        if (r_s2 == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt >= DB_LAST) begin
          r_level <= r_s2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end

    assign w_level[g] = r_level;
    assign w_rise[g]  = r_level & ~r_level_q;
  end

  logic w_set_req;
  logic w_reset_req;
  logic w_set_keep;

  assign w_set_req   = w_rise[0];
  assign w_reset_req = w_rise[1];
  // On a collision reset wins and the set request is discarded outright.
  assign w_set_keep  = w_set_req & ~w_reset_req;

  state_t           r_state,  w_state_next;
  logic [CNT_W-1:0] r_pcnt,   w_pcnt_next;
  logic             r_pend_s, w_pend_s_next;
  logic             r_pend_r, w_pend_r_next;
  logic             r_set;
  logic             r_reset;
  logic             r_conflict;
  logic             w_last;

  // NOTE: every always_comb output gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_next  = r_state;
    w_pcnt_next   = r_pcnt;
    w_pend_s_next = r_pend_s;
    w_pend_r_next = r_pend_r;
    w_last        = (r_pcnt >= P_LAST);

    case (r_state)
      IDLE: begin
        w_pcnt_next = '0;
        if (w_reset_req || r_pend_r) begin
          w_state_next  = RST_P;
          w_pend_r_next = 1'b0;
          w_pend_s_next = r_pend_s | w_set_keep;
        end else if (w_set_req || r_pend_s) begin
          w_state_next  = SET_P;
          w_pend_s_next = 1'b0;
        end
      end

      SET_P: begin
        if (w_reset_req) w_pend_r_next = 1'b1;
        if (w_last) begin
          w_pcnt_next = '0;
          if (w_pend_r_next) begin
            w_state_next  = RST_P;
            w_pend_r_next = 1'b0;
          end else begin
            w_state_next = IDLE;
          end
        end else begin
          w_pcnt_next = r_pcnt + CNT_W'(1);
        end
      end

      RST_P: begin
        if (w_set_keep) w_pend_s_next = 1'b1;
        if (w_last) begin
          w_pcnt_next = '0;
          if (w_pend_s_next) begin
            w_state_next  = SET_P;
            w_pend_s_next = 1'b0;
          end else begin
            w_state_next = IDLE;
          end
        end else begin
          w_pcnt_next = r_pcnt + CNT_W'(1);
        end
      end

      default: begin
        w_state_next = IDLE;
        w_pcnt_next  = '0;
      end
    endcase
  end

  // NOTE: outputs are flops of the next-state decode, so the async reset
  // clears them immediately, even mid-pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pcnt     <= '0;
      r_pend_s   <= 1'b0;
      r_pend_r   <= 1'b0;
      r_set      <= 1'b0;
      r_reset    <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pcnt     <= w_pcnt_next;
      r_pend_s   <= w_pend_s_next;
      r_pend_r   <= w_pend_r_next;
      r_set      <= (w_state_next == SET_P);
      r_reset    <= (w_state_next == RST_P);
      r_conflict <= w_set_req & w_reset_req;
    end
  end

  assign set         = r_set;
  assign reset       = r_reset;
  assign set_level   = w_level[0];
  assign reset_level = w_level[1];
  assign conflict    = r_conflict;

endmodule

// File: tb/tb_sr_pulse_gen.sv
// Bench for sr_pulse_gen with DB_CYCLES=4, PULSE_LEN=2: vector table of raw
// input windows with expected output windows, checked edge by edge via a queue.
module tb_sr_pulse_gen;

  logic clk;
  logic rst_n;
  logic set_raw;
  logic reset_raw;
  logic set;
  logic reset;
  logic set_level;
  logic reset_level;
  logic conflict;

  int n_checks = 0;
  int n_fail   = 0;

  sr_pulse_gen #(
    .DB_CYCLES(4),
    .PULSE_LEN(2),
    .CNT_W    (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_raw    (set_raw),
    .reset_raw  (reset_raw),
    .set        (set),
    .reset      (reset),
    .set_level  (set_level),
    .reset_level(reset_level),
    .conflict   (conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge k is the k-th rising edge after the raw inputs are first driven.
  // Windows are [on, off) for raw/levels and [a, b] for pulses; 0,0 = never.
  typedef struct {
    string name;
    int s_on, s_off, r_on, r_off, n;
    int sl_on, sl_off, rl_on, rl_off;
    int sp_a, sp_b, rp_a, rp_b, cf;
  } vec_t;

  typedef struct {
    string      name;
    int         k;
    logic [4:0] exp;
  } sb_t;

  sb_t sb_q[$];

  function automatic logic [4:0] obs();
    return {set_level, reset_level, set, reset, conflict};
  endfunction

  function automatic logic [4:0] expect_at(vec_t v, int k);
    logic [4:0] e;
    e[4] = (k >= v.sl_on) && (k < v.sl_off);
    e[3] = (k >= v.rl_on) && (k < v.rl_off);
    e[2] = (k >= v.sp_a) && (k <= v.sp_b) && (v.sp_a != 0);
    e[1] = (k >= v.rp_a) && (k <= v.rp_b) && (v.rp_a != 0);
    e[0] = (k == v.cf);
    return e;
  endfunction

  task automatic check(string name, logic [4:0] act, logic [4:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {sl,rl,set,rst,cf}=%b expected %b", name, act, exp);
    end
  endtask

  // Ends on a falling edge with rst_n released and raw inputs low.
  task automatic apply_reset();
    set_raw   = 1'b0;
    reset_raw = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("reset_state", obs(), 5'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Must be entered between a falling edge and the next rising edge.
  task automatic run_vec(vec_t v, bit do_reset);
    sb_t e;
    if (do_reset) apply_reset();
    for (int k = 1; k <= v.n; k++) begin
      set_raw   = (k >= v.s_on) && (k < v.s_off);
      reset_raw = (k >= v.r_on) && (k < v.r_off);
      sb_q.push_back('{v.name, k, expect_at(v, k)});
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check($sformatf("%s edge%0d", e.name, e.k), obs(), e.exp);
      @(negedge clk);
    end
  endtask

  // Set and reset must never be high together.
  always @(negedge clk) check("exclusive", {4'b0, set & reset}, 5'b0);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[8];
    vec_t pre_rst, post_rst;
    sb_t  e;

    //            name            s_on s_off r_on r_off n   sl_on sl_off rl_on rl_off sp_a sp_b rp_a rp_b cf
    vecs[0] = '{"hold12",         1,   13,   0,   0,    22, 6,    18,    0,    0,     7,   8,   0,   0,   0};
    vecs[1] = '{"short3",         1,   4,    0,   0,    12, 0,    0,     0,    0,     0,   0,   0,   0,   0};
    vecs[2] = '{"exact4",         1,   5,    0,   0,    14, 6,    10,    0,    0,     7,   8,   0,   0,   0};
    vecs[3] = '{"both_same",      1,   100,  1,   100,  14, 6,    100,   6,    100,   0,   0,   7,   8,   7};
    vecs[4] = '{"set_then_rst",   1,   100,  2,   100,  16, 6,    100,   7,    100,   7,   8,   9,   10,  0};
    vecs[5] = '{"drop_both",      0,   0,    0,   0,    12, 1,    6,     1,    6,     0,   0,   0,   0,   0};
    vecs[6] = '{"rst_then_set",   2,   100,  1,   100,  16, 7,    100,   6,    100,   9,   10,  7,   8,   0};
    vecs[7] = '{"release",        1,   10,   0,   0,    20, 6,    15,    0,    0,     7,   8,   0,   0,   0};
    pre_rst  = '{"pre_rst",       1,   100,  0,   0,    7,  6,    100,   0,    0,     7,   8,   0,   0,   0};
    post_rst = '{"post_rst",      1,   100,  0,   0,    12, 6,    100,   0,    0,     7,   8,   0,   0,   0};

    set_raw   = 1'b0;
    reset_raw = 1'b0;
    rst_n     = 1'b0;

    for (int i = 0; i < 8; i++) begin
      // drop_both continues from set_then_rst to show falling levels give no pulse.
      run_vec(vecs[i], vecs[i].name != "drop_both");
    end

    // Every-cycle chatter never qualifies.
    apply_reset();
    for (int k = 1; k <= 28; k++) begin
      set_raw = (k <= 20) ? k[0] : 1'b0;
      sb_q.push_back('{"chatter", k, 5'b0});
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check($sformatf("%s edge%0d", e.name, e.k), obs(), e.exp);
      @(negedge clk);
    end
    set_raw = 1'b0;

    // Async reset mid-pulse with the button held through release.
    run_vec(pre_rst, 1'b1);
    check("pulse_live", obs(), 5'b10100);
    rst_n = 1'b0;
    #1;
    check("async_clear", obs(), 5'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("reset_held", obs(), 5'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(post_rst, 1'b0);

    set_raw = 1'b0;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
